xf100_exu_wbck: RTL and testbench

XF100_EXU_WBCK -- requirements
Module: xf100_exu_wbck

---
 rtl/xf100_exu_wbck.sv | 101 ++++++++++
 tb/tb_xf100_exu_wbck.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/xf100_exu_wbck.sv
// xf100_exu_wbck
// Final writeback arbiter for the xf100 execution unit. It takes results from
// the single-cycle ALU and from the long pipe (loads), picks one per cycle,
// and registers the winner onto the register-file write port.
//
// The long pipe normally wins, because its results hold up later dependent
// instructions. A small starvation counter stops a busy long pipe from
// locking the ALU out. After STARVE_LIMIT consecutive denied ALU cycles, the
// ALU gets the next slot regardless. Legal STARVE_LIMIT values are 1..15,
// because the counter is 4 bits wide.

module xf100_exu_wbck #(
   parameter int XLEN         = 32,
   parameter int RFIDX_W      = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,

   input  logic               alu_wbck_i_valid,
   output logic               alu_wbck_i_ready,
   input  logic [XLEN-1:0]    alu_wbck_i_data,
   input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,

   input  logic               lsu_wbck_i_valid,
   output logic               lsu_wbck_i_ready,
   input  logic [XLEN-1:0]    lsu_wbck_i_data,
   input  logic [RFIDX_W-1:0] lsu_wbck_i_rdidx,

   output logic               rf_wbck_o_ena,
   output logic [XLEN-1:0]    rf_wbck_o_wdat,
   output logic [RFIDX_W-1:0] rf_wbck_o_rdidx
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [3:0]         starve_cnt;
   logic [3:0]         starve_cnt_nxt;
   logic               alu_starved;
   logic               alu_grant;
   logic               lsu_grant;
   logic               wbck_hsk;
   logic [XLEN-1:0]    wbck_wdat;
   logic [RFIDX_W-1:0] wbck_rdidx;

   // Arbitration: the long pipe has priority unless the ALU has waited long enough
   always_comb begin
      alu_starved = (starve_cnt == STARVE_MAX);
      alu_grant   = alu_wbck_i_valid & (~lsu_wbck_i_valid | alu_starved);
      lsu_grant   = lsu_wbck_i_valid & ~alu_grant;
      wbck_hsk    = alu_grant | lsu_grant;
   end

   assign alu_wbck_i_ready = alu_grant;
   assign lsu_wbck_i_ready = lsu_grant;

   // Select the winning source's payload for capture
   always_comb begin
      wbck_wdat  = lsu_wbck_i_data;
      wbck_rdidx = lsu_wbck_i_rdidx;
      if (alu_grant) begin
         wbck_wdat  = alu_wbck_i_data;
         wbck_rdidx = alu_wbck_i_rdidx;
      end
   end

   // Count denied ALU cycles; restart whenever the ALU wins or stops asking
   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (~alu_wbck_i_valid || alu_grant) begin
         starve_cnt_nxt = 4'd0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt_nxt = starve_cnt + 4'd1;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 4'd0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Register-file write port: enable pulses for one cycle per accepted result, never for x0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wbck_o_ena   <= 1'b0;
         rf_wbck_o_wdat  <= '0;
         rf_wbck_o_rdidx <= '0;
      end else begin
         rf_wbck_o_ena <= wbck_hsk & (wbck_rdidx != '0);
         if (wbck_hsk) begin
            rf_wbck_o_wdat  <= wbck_wdat;
            rf_wbck_o_rdidx <= wbck_rdidx;
         end
      end
   end

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// tb_xf100_exu_wbck
// Directed bench for the writeback arbiter. The driver applies one vector per
// cycle and checks the combinational readies against hand-written grants. It
// then queues the register-file write expected after the next edge. A
// separate monitor pops that queue every cycle and compares the registered
// outputs. A second instance with STARVE_LIMIT=1 shares the inputs. Its
// readies are checked only in a window that starts right after a common reset.

module tb_xf100_exu_wbck;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [31:0] alu_data;
   logic [4:0]  alu_rdidx;
   logic        lsu_valid;
   logic [31:0] lsu_data;
   logic [4:0]  lsu_rdidx;

   logic        alu_ready;
   logic        lsu_ready;
   logic        rf_ena;
   logic [31:0] rf_wdat;
   logic [4:0]  rf_rdidx;

   logic        alu_ready_l1;
   logic        lsu_ready_l1;
   logic        rf_ena_l1;
   logic [31:0] rf_wdat_l1;
   logic [4:0]  rf_rdidx_l1;

   typedef struct {
      logic        ena;
      logic [31:0] wdat;
      logic [4:0]  rdidx;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_bad    = 0;
   logic [31:0] last_wdat = 32'h0;
   logic [4:0]  last_rdidx = 5'h0;

   xf100_exu_wbck #(.XLEN(32), .RFIDX_W(5), .STARVE_LIMIT(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .alu_wbck_i_valid (alu_valid),
      .alu_wbck_i_ready (alu_ready),
      .alu_wbck_i_data  (alu_data),
      .alu_wbck_i_rdidx (alu_rdidx),
      .lsu_wbck_i_valid (lsu_valid),
      .lsu_wbck_i_ready (lsu_ready),
      .lsu_wbck_i_data  (lsu_data),
      .lsu_wbck_i_rdidx (lsu_rdidx),
      .rf_wbck_o_ena    (rf_ena),
      .rf_wbck_o_wdat   (rf_wdat),
      .rf_wbck_o_rdidx  (rf_rdidx)
   );

   xf100_exu_wbck #(.XLEN(32), .RFIDX_W(5), .STARVE_LIMIT(1)) dut_l1 (
      .clk              (clk),
      .rst_n            (rst_n),
      .alu_wbck_i_valid (alu_valid),
      .alu_wbck_i_ready (alu_ready_l1),
      .alu_wbck_i_data  (alu_data),
      .alu_wbck_i_rdidx (alu_rdidx),
      .lsu_wbck_i_valid (lsu_valid),
      .lsu_wbck_i_ready (lsu_ready_l1),
      .lsu_wbck_i_data  (lsu_data),
      .lsu_wbck_i_rdidx (lsu_rdidx),
      .rf_wbck_o_ena    (rf_ena_l1),
      .rf_wbck_o_wdat   (rf_wdat_l1),
      .rf_wbck_o_rdidx  (rf_rdidx_l1)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // One cycle of stimulus; ea/el are the hand-computed grants for the default instance
   task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] ard,
                                input logic lv, input logic [31:0] ld, input logic [4:0] lrd,
                                input logic ea, input logic el,
                                input logic chk1, input logic e1a, input logic e1l,
                                input string tag);
      exp_t e;
      @(negedge clk);
      alu_valid = av;
      alu_data  = ad;
      alu_rdidx = ard;
      lsu_valid = lv;
      lsu_data  = ld;
      lsu_rdidx = lrd;
      #1;
      checkOutput({tag, ".alu_ready"}, {31'b0, alu_ready}, {31'b0, ea});
      checkOutput({tag, ".lsu_ready"}, {31'b0, lsu_ready}, {31'b0, el});
      if (chk1) begin
         checkOutput({tag, ".l1.alu_ready"}, {31'b0, alu_ready_l1}, {31'b0, e1a});
         checkOutput({tag, ".l1.lsu_ready"}, {31'b0, lsu_ready_l1}, {31'b0, e1l});
      end
      if (ea) begin
         last_wdat  = ad;
         last_rdidx = ard;
         e.ena      = (ard != 5'd0);
      end else if (el) begin
         last_wdat  = ld;
         last_rdidx = lrd;
         e.ena      = (lrd != 5'd0);
      end else begin
         e.ena      = 1'b0;
      end
      e.wdat  = last_wdat;
      e.rdidx = last_rdidx;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: after every edge compare the write port against the next queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.tag, ".ena"},   {31'b0, rf_ena},  {31'b0, e.ena});
            checkOutput({e.tag, ".wdat"},  rf_wdat,          e.wdat);
            checkOutput({e.tag, ".rdidx"}, {27'b0, rf_rdidx}, {27'b0, e.rdidx});
         end else begin
            checkOutput("idle.ena", {31'b0, rf_ena}, 32'h0);
         end
      end
   end

   // Directed sequence
   initial begin
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      alu_data  = 32'h0;
      alu_rdidx = 5'h0;
      lsu_valid = 1'b0;
      lsu_data  = 32'h0;
      lsu_rdidx = 5'h0;

      #12;
      checkOutput("reset.ena",   {31'b0, rf_ena},   32'h0);
      checkOutput("reset.wdat",  rf_wdat,           32'h0);
      checkOutput("reset.rdidx", {27'b0, rf_rdidx}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "idle0");

      applyStimulus(1, 32'h0000_00AA, 5'd5, 0, 32'h0, 5'd0, 1, 0, 0, 0, 0, "alu_only");
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "alu_only_after");

      applyStimulus(1, 32'hFFFF_FFFF, 5'd0, 0, 32'h0, 5'd0, 1, 0, 0, 0, 0, "x0_write");
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "x0_after");

      applyStimulus(0, 32'h0, 5'd0, 1, 32'h0000_0011, 5'd3, 0, 1, 0, 0, 0, "b2b_lsu");
      applyStimulus(1, 32'h0000_0022, 5'd4, 0, 32'h0, 5'd0, 1, 0, 0, 0, 0, "b2b_alu");

      applyStimulus(1, 32'hA000_0001, 5'd8, 1, 32'h5000_0001, 5'd9, 0, 1, 0, 0, 0, "drop.c1");
      applyStimulus(1, 32'hA000_0002, 5'd8, 1, 32'h5000_0002, 5'd9, 0, 1, 0, 0, 0, "drop.c2");
      applyStimulus(0, 32'hA000_0003, 5'd8, 1, 32'h5000_0003, 5'd9, 0, 1, 0, 0, 0, "drop.gap");
      applyStimulus(1, 32'hA000_0004, 5'd8, 1, 32'h5000_0004, 5'd9, 0, 1, 0, 0, 0, "drop.r1");
      applyStimulus(1, 32'hA000_0005, 5'd8, 1, 32'h5000_0005, 5'd9, 0, 1, 0, 0, 0, "drop.r2");
      applyStimulus(1, 32'hA000_0006, 5'd8, 1, 32'h5000_0006, 5'd9, 0, 1, 0, 0, 0, "drop.r3");
      applyStimulus(1, 32'hA000_0007, 5'd8, 1, 32'h5000_0007, 5'd9, 0, 1, 0, 0, 0, "drop.r4");
      applyStimulus(1, 32'hA000_0008, 5'd8, 1, 32'h5000_0008, 5'd9, 1, 0, 0, 0, 0, "drop.r5");

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 32'hA100_0000 + 32'(i), 5'd10, 1, 32'h5100_0000 + 32'(i), 5'd20,
                       (i % 5) == 4, (i % 5) != 4, 0, 0, 0, $sformatf("sat.%0d", i));
      end
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "sat_after");

      @(negedge clk);
      alu_valid = 1'b1;
      alu_data  = 32'h0000_0077;
      alu_rdidx = 5'd7;
      #1;
      checkOutput("midrst.alu_ready", {31'b0, alu_ready}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.ena",   {31'b0, rf_ena},   32'h0);
      checkOutput("midrst.wdat",  rf_wdat,           32'h0);
      checkOutput("midrst.rdidx", {27'b0, rf_rdidx}, 32'h0);
      @(negedge clk);
      alu_valid = 1'b0;
      alu_data  = 32'h0;
      alu_rdidx = 5'h0;
      #1;
      rst_n = 1'b1;
      last_wdat  = 32'h0;
      last_rdidx = 5'h0;
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "postrst.idle0");
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "postrst.idle1");

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 32'hA200_0000 + 32'(i), 5'd11, 1, 32'h5200_0000 + 32'(i), 5'd21,
                       i == 4, i != 4, 1, (i % 2) == 1, (i % 2) == 0,
                       $sformatf("lim1.%0d", i));
      end
      applyStimulus(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0, "final_idle");

      repeat (3) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_bad++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
